// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared widths, reset PC and FSM encoding for the fetch stage
package if_fetch_stage_pkg;

  localparam int IF_REG_BUS_LEN = 64;
  localparam int BR_BUS_LEN = 33;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C000000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  // Sequential next PC; wraps modulo 2^32 by construction.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - SRAM-like instruction bus between fetch stage and memory
interface if_fetch_stage_if;

  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage: PC, single-outstanding fetch FSM, branch squash
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      resetn,
  if_fetch_stage_if.master          inst_sram,
  input  logic [BR_BUS_LEN-1:0]     BR_BUS,
  input  logic                      ID_ready_go,
  input  logic                      ID_allow_in,
  output logic                      IF_valid,
  output logic                      IF_ready_go,
  output logic [IF_REG_BUS_LEN-1:0] IFreg_bus
);

  fetch_state_t state, state_nxt;
  logic [31:0]  npc_r, npc_nxt;
  logic [31:0]  fs_pc, fs_pc_nxt;
  logic [31:0]  inst_buf, inst_buf_nxt;
  logic         discard, discard_nxt;
  // Target of a branch seen while a request is still waiting for addr_ok;
  // the request address must stay put, so the redirect is applied on acceptance.
  logic [31:0]  redir_r, redir_nxt;

  logic [31:0]  br_target;
  logic         br_taken;
  logic         br_valid;
  logic         ready_go;
  logic [31:0]  inst;

  assign br_target = BR_BUS[32:1];
  assign br_taken  = BR_BUS[0];
  assign br_valid  = br_taken & ID_ready_go;

  assign inst_sram.wr    = 1'b0;
  assign inst_sram.size  = 2'd2;
  assign inst_sram.wstrb = 4'h0;
  assign inst_sram.wdata = 32'h0;
  assign inst_sram.addr  = npc_r;
  assign inst_sram.req   = (state == S_REQ);

  assign IF_valid    = ((state == S_WAIT) || (state == S_HOLD)) && !discard;
  assign IF_ready_go = ready_go;
  assign IFreg_bus   = ready_go ? {inst, fs_pc} : '0;

  // Next-state, register updates and handshake outputs of the fetch FSM.
  always_comb begin
    state_nxt    = state;
    npc_nxt      = npc_r;
    fs_pc_nxt    = fs_pc;
    inst_buf_nxt = inst_buf;
    discard_nxt  = discard;
    redir_nxt    = redir_r;
    ready_go     = 1'b0;
    inst         = inst_buf;
    case (state)
      S_REQ: begin
        if (inst_sram.addr_ok) begin
          fs_pc_nxt = npc_r;
          state_nxt = S_WAIT;
          if (br_valid) begin
            npc_nxt     = br_target;
            discard_nxt = 1'b1;
          end else if (discard) begin
            npc_nxt = redir_r;
          end else begin
            npc_nxt = seq_pc(npc_r);
          end
        end else if (br_valid) begin
          discard_nxt = 1'b1;
          redir_nxt   = br_target;
        end
      end
      S_WAIT: begin
        if (br_valid) begin
          npc_nxt = br_target;
          if (inst_sram.data_ok) begin
            discard_nxt = 1'b0;
            state_nxt   = S_REQ;
          end else begin
            discard_nxt = 1'b1;
          end
        end else if (inst_sram.data_ok) begin
          if (discard) begin
            discard_nxt = 1'b0;
            state_nxt   = S_REQ;
          end else begin
            ready_go = 1'b1;
            inst     = inst_sram.rdata;
            if (ID_allow_in) begin
              state_nxt = S_REQ;
            end else begin
              inst_buf_nxt = inst_sram.rdata;
              state_nxt    = S_HOLD;
            end
          end
        end
      end
      S_HOLD: begin
        if (br_valid) begin
          npc_nxt   = br_target;
          state_nxt = S_REQ;
        end else begin
          ready_go = 1'b1;
          if (ID_allow_in) state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_REQ;
      npc_r    <= RESET_PC;
      fs_pc    <= 32'h0;
      inst_buf <= 32'h0;
      discard  <= 1'b0;
      redir_r  <= 32'h0;
    end else begin
      state    <= state_nxt;
      npc_r    <= npc_nxt;
      fs_pc    <= fs_pc_nxt;
      inst_buf <= inst_buf_nxt;
      discard  <= discard_nxt;
      redir_r  <= redir_nxt;
    end
  end

endmodule
